// File: rtl/uart_rx_ctrl_if.sv
// Receive-side valid/ready handshake between the UART receiver and its consumer.
// The master drives data/valid; the slave answers with ready.
interface uart_rx_ctrl_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive sequencer: line sync, start detect, mid-bit sampling from a runtime divisor,
// stop check and a one-entry valid/ready holding register with framing-error and overrun flags.
module uart_rx_ctrl #(
    parameter int unsigned BAUD_W = 20,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [BAUD_W-1:0] baud_i,
    input  logic              rx_en_i,
    input  logic              rx_in_i,
    input  logic              ovr_clr_i,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o,
    uart_rx_ctrl_if.master    rx_if
);
    localparam int unsigned IdxW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   cnt_q, cnt_d;
    logic [BAUD_W-1:0]   baud_l_q, baud_l_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                ferr_q, ferr_d;
    logic                sync1_q, rxs_q, rxp_q;
    logic                deliver;
    logic                accept;
    logic [BAUD_W-1:0]   half_m1;
    logic [BAUD_W-1:0]   full_m1;

    assign half_m1 = (baud_l_q >> 1) - BAUD_W'(1);
    assign full_m1 = baud_l_q - BAUD_W'(1);
    assign accept  = valid_q & rx_if.rx_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        baud_l_d = baud_l_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        deliver  = 1'b0;
        ferr_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_en_i && !rxs_q && rxp_q) begin
                    // Divisors below 2 cannot produce a half-bit point, so clamp them.
                    baud_l_d = (baud_i < BAUD_W'(2)) ? BAUD_W'(2) : baud_i;
                    cnt_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (cnt_q == half_m1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end
            end
            StData: begin
                if (cnt_q == full_m1) begin
                    shift_d = {rxs_q, shift_q[DATA_W-1:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + IdxW'(1);
                    if (idx_q == IdxW'(DATA_W - 1)) state_d = StStop;
                end else begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end
            end
            StStop: begin
                if (cnt_q == full_m1) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    deliver = rxs_q;
                    ferr_d  = ~rxs_q;
                end else begin
                    cnt_d = cnt_q + BAUD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (!rx_en_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
            deliver = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (ovr_clr_i) ovr_d = 1'b0;
        if (deliver) begin
            if (!valid_q || accept) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            baud_l_q <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            sync1_q  <= 1'b1;
            rxs_q    <= 1'b1;
            rxp_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            baud_l_q <= baud_l_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            sync1_q  <= rx_in_i;
            rxs_q    <= sync1_q;
            rxp_q    <= rxs_q;
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign frame_err_o    = ferr_q;
    assign overrun_o      = ovr_q;
    assign busy_o         = (state_q != StIdle);
endmodule
